apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_slv_pkg.sv | 35 +++
 rtl/apb_slv_if.sv | 21 ++
 rtl/apb_slv_regfile.sv | 81 ++++++++
 rtl/apb_reg_slave.sv | 99 +++++++++
 tb/tb_apb_reg_slave.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB byte-register slave.
// Wait-state support is built only when APB_SLV_WAIT_EN is defined.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam int WAIT_W_DEF   = 2;
    localparam int NUM_REGS_DEF = 8;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_XFER_CNT = 8'h01;
    localparam logic [7:0] ADDR_DATA0    = 8'h02;
    localparam logic [7:0] ADDR_DATA1    = 8'h03;
    localparam logic [7:0] ADDR_DATA2    = 8'h04;
    localparam logic [7:0] ADDR_DATA3    = 8'h05;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h06;
    localparam logic [7:0] ADDR_WAIT_CFG = 8'h07;

    localparam logic [7:0] RST_CTRL     = 8'h00;
    localparam logic [7:0] RST_DATA     = 8'h00;
    localparam logic [7:0] RST_SCRATCH  = 8'h00;
    localparam logic [7:0] RST_WAIT_CFG = 8'h00;
    localparam logic [7:0] RST_XFER_CNT = 8'h00;

    // Out-of-map accesses and writes to the read-only counter are errors.
    function automatic logic addr_err(input logic [7:0] addr, input logic wr,
                                      input int num_regs);
        return (int'({24'd0, addr}) >= num_regs) || (wr && (addr == ADDR_XFER_CNT));
    endfunction

endpackage

// File: rtl/apb_slv_if.sv
// APB bus bundle between a master and the byte-register slave.
interface apb_slv_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_slv_regfile.sv
// Register storage, address decode and read mux for the APB slave.
// WAIT_CFG storage exists only when APB_SLV_WAIT_EN is defined.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              wr_en,
    input  logic              wr,
    input  logic [7:0]        addr,
    input  logic [7:0]        wdata,
    input  logic [7:0]        xfer_cnt,
    output logic              err,
    output logic [7:0]        rdata,
    output logic [7:0]        ctrl
`ifdef APB_SLV_WAIT_EN
    ,output logic [WAIT_W-1:0] wait_cfg
`endif
);

    logic [7:0]        ctrl_q;
    logic [7:0]        data_q [4];
    logic [7:0]        scratch_q;
    logic [WAIT_W-1:0] wait_cfg_q;

    assign err  = addr_err(addr, wr, NUM_REGS);
    assign ctrl = ctrl_q;

`ifdef APB_SLV_WAIT_EN
    assign wait_cfg = wait_cfg_q;
`else
    assign wait_cfg_q = '0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_q    <= RST_CTRL;
            scratch_q <= RST_SCRATCH;
            for (int i = 0; i < 4; i++) data_q[i] <= RST_DATA;
`ifdef APB_SLV_WAIT_EN
            wait_cfg_q <= WAIT_W'(RST_WAIT_CFG);
`endif
        end else if (wr_en && !err) begin
            case (addr)
                ADDR_CTRL:    ctrl_q    <= wdata;
                ADDR_DATA0:   data_q[0] <= wdata;
                ADDR_DATA1:   data_q[1] <= wdata;
                ADDR_DATA2:   data_q[2] <= wdata;
                ADDR_DATA3:   data_q[3] <= wdata;
                ADDR_SCRATCH: scratch_q <= wdata;
                ADDR_WAIT_CFG: begin
`ifdef APB_SLV_WAIT_EN
                    wait_cfg_q <= wdata[WAIT_W-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (!err) begin
            case (addr)
                ADDR_CTRL:     rdata = ctrl_q;
                ADDR_XFER_CNT: rdata = xfer_cnt;
                ADDR_DATA0:    rdata = data_q[0];
                ADDR_DATA1:    rdata = data_q[1];
                ADDR_DATA2:    rdata = data_q[2];
                ADDR_DATA3:    rdata = data_q[3];
                ADDR_SCRATCH:  rdata = scratch_q;
                ADDR_WAIT_CFG: rdata = 8'(wait_cfg_q);
                default:       rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB byte-register slave: protocol FSM, wait counter and transfer counter.
// Define APB_SLV_WAIT_EN to build programmable wait states (WAIT_CFG).
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no transfer in flight; any psel cycle is taken as setup
//   ST_SETUP  | setup seen; the next psel&penable cycle is the 1st access
//   ST_ACCESS | access phase held by wait states, waiting for completion
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic       pclk,
    input  logic       presetn,
    apb_slv_if.slave   bus,
    output logic [7:0] ctrl_o
);

    apb_state_t state;
    logic [7:0] xfer_cnt;
    logic [7:0] rdata;
    logic       access;
    logic       wait_done;
    logic       complete;
    logic       err;
    logic       wr_en;

    // penable straight out of idle is only a setup, so it never completes.
    assign access   = bus.psel & bus.penable & (state != ST_IDLE);
    assign complete = access & wait_done;
    assign wr_en    = complete & bus.pwrite;

    assign bus.pready  = complete;
    assign bus.pslverr = complete & err;
    assign bus.prdata  = (complete & ~bus.pwrite & ~err) ? rdata : 8'h00;

`ifdef APB_SLV_WAIT_EN
    logic [WAIT_W-1:0] wait_cfg;
    logic [WAIT_W-1:0] wcnt;

    assign wait_done = (wcnt == wait_cfg);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt <= '0;
        end else if (access && !wait_done) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= ST_IDLE;
            xfer_cnt <= RST_XFER_CNT;
        end else begin
            if (complete) xfer_cnt <= xfer_cnt + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (bus.psel) state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!bus.psel)          state <= ST_IDLE;
                    else if (bus.penable)   state <= complete ? ST_IDLE : ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!bus.psel || complete) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_slv_regfile #(
        .WAIT_W   (WAIT_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .pclk     (pclk),
        .presetn  (presetn),
        .wr_en    (wr_en),
        .wr       (bus.pwrite),
        .addr     (bus.paddr),
        .wdata    (bus.pwdata),
        .xfer_cnt (xfer_cnt),
        .err      (err),
        .rdata    (rdata),
        .ctrl     (ctrl_o)
`ifdef APB_SLV_WAIT_EN
        ,.wait_cfg (wait_cfg)
`endif
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed self-checking bench for apb_reg_slave (default or APB_SLV_WAIT_EN build).
module tb_apb_reg_slave;

`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       pclk;
    logic       presetn;
    logic [7:0] ctrl_o;
    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] exp_cnt = 8'h00;

    apb_slv_if bus ();

    apb_reg_slave dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus),
        .ctrl_o  (ctrl_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    // One full transfer; consecutive calls run back-to-back with no idle gap.
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err, output int nw,
                            output logic [7:0] ctrl_done);
        exp_cnt = exp_cnt + 8'd1;
        @(negedge pclk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = wd;
        @(negedge pclk);
        bus.penable = 1'b1;
        nw = 0; rd = 8'h00; err = 1'b0; ctrl_done = 8'h00;
        while (1) begin
            #1;
            if (bus.pready) begin
                rd = bus.prdata; err = bus.pslverr; ctrl_done = ctrl_o;
                break;
            end
            if (nw >= 32) begin
                chk("xfer_timeout", 32'(bus.pready), 32'd1);
                break;
            end
            nw++;
            @(negedge pclk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, cd, prev;
        logic       er;
        int         nw, wsum;
        int         exp_w3;

        exp_w3 = WAIT_EN ? 3 : 0;
        presetn = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 8'h00; bus.pwdata = 8'h00;
        #2;
        chk("rst_pready",  bus.pready,  0);
        chk("rst_pslverr", bus.pslverr, 0);
        chk("rst_prdata",  bus.prdata,  0);
        chk("rst_ctrl",    ctrl_o,      0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write then readback, counter sees two prior transfers
        apb_xfer(1'b1, 8'h02, 8'hA5, rd, er, nw, cd);
        chk("wr02_waits", nw, 0);
        chk("wr02_err", er, 0);
        chk("wr02_prdata", rd, 8'h00);
        apb_xfer(1'b0, 8'h02, 8'h00, rd, er, nw, cd);
        chk("rd02_waits", nw, 0);
        chk("rd02_data", rd, 8'hA5);
        chk("rd02_err", er, 0);
        apb_xfer(1'b0, 8'h01, 8'h00, rd, er, nw, cd);
        chk("xfer_cnt_2", rd, 8'h02);

        // CTRL commits only at the completing edge
        apb_xfer(1'b1, 8'h00, 8'h3C, rd, er, nw, cd);
        chk("ctrl_before_commit", cd, 8'h00);
        bus_idle();
        #1;
        chk("ctrl_after_commit", ctrl_o, 8'h3C);

        // WAIT_CFG=3: the programming write still uses the old zero-wait value
        apb_xfer(1'b1, 8'h07, 8'h03, rd, er, nw, cd);
        chk("wcfg_wr_waits", nw, 0);
        chk("wcfg_wr_err", er, 0);
        apb_xfer(1'b0, 8'h06, 8'h00, rd, er, nw, cd);
        chk("rd06_waits", nw, exp_w3);
        chk("rd06_data", rd, 8'h00);
        apb_xfer(1'b0, 8'h07, 8'h00, rd, er, nw, cd);
        chk("rd07_data", rd, WAIT_EN ? 8'h03 : 8'h00);
        apb_xfer(1'b1, 8'h06, 8'h5A, rd, er, nw, cd);
        chk("wr06_waits", nw, exp_w3);
        apb_xfer(1'b0, 8'h06, 8'h00, rd, er, nw, cd);
        chk("rd06_5a", rd, 8'h5A);

        // Error cases and map boundary
        prev = exp_cnt;
        apb_xfer(1'b1, 8'h01, 8'h55, rd, er, nw, cd);
        chk("wr01_err", er, 1);
        apb_xfer(1'b0, 8'h20, 8'h00, rd, er, nw, cd);
        chk("rd20_err", er, 1);
        chk("rd20_data", rd, 8'h00);
        apb_xfer(1'b0, 8'h08, 8'h00, rd, er, nw, cd);
        chk("rd08_err", er, 1);
        apb_xfer(1'b1, 8'h08, 8'hEE, rd, er, nw, cd);
        chk("wr08_err", er, 1);
        apb_xfer(1'b0, 8'h07, 8'h00, rd, er, nw, cd);
        chk("rd07_err", er, 0);
        apb_xfer(1'b0, 8'h01, 8'h00, rd, er, nw, cd);
        chk("xfer_cnt_err", rd, prev + 8'd5);

        // Abort: WAIT_CFG=2, drop psel after one wait cycle
        apb_xfer(1'b1, 8'h00, 8'h00, rd, er, nw, cd);
        apb_xfer(1'b1, 8'h07, 8'h02, rd, er, nw, cd);
        bus_idle();
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h11;
`ifdef APB_SLV_WAIT_EN
        @(negedge pclk);
        bus.penable = 1'b1;
        #1;
        chk("abort_wait_pready", bus.pready, 0);
`endif
        bus_idle();
        #1;
        chk("abort_ctrl", ctrl_o, 8'h00);
        prev = exp_cnt;
        apb_xfer(1'b0, 8'h01, 8'h00, rd, er, nw, cd);
        chk("abort_xfer_cnt", rd, prev);
        apb_xfer(1'b0, 8'h07, 8'h00, rd, er, nw, cd);
        chk("wcfg2_waits", nw, WAIT_EN ? 2 : 0);

        // penable without a preceding setup cycle must not complete
        bus_idle();
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h22;
        #1;
        chk("nosetup_pready", bus.pready, 0);
        bus_idle();
        #1;
        chk("nosetup_ctrl", ctrl_o, 8'h00);

        // 256 back-to-back completions from reset wrap the counter
        @(negedge pclk);
        presetn = 1'b0;
        exp_cnt = 8'h00;
        @(negedge pclk);
        presetn = 1'b1;
        wsum = 0;
        for (int i = 0; i < 256; i++) begin
            apb_xfer(1'b0, 8'h02, 8'h00, rd, er, nw, cd);
            wsum += nw;
        end
        chk("b2b_waits", wsum, 0);
        chk("data_after_reset", rd, 8'h00);
        apb_xfer(1'b0, 8'h01, 8'h00, rd, er, nw, cd);
        chk("xfer_cnt_wrap", rd, 8'h00);

        // Reset asserted mid-access on a CTRL write
        apb_xfer(1'b1, 8'h00, 8'h77, rd, er, nw, cd);
        apb_xfer(1'b1, 8'h07, 8'h03, rd, er, nw, cd);
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h99;
        @(negedge pclk);
        bus.penable = 1'b1;
        #1;
        presetn = 1'b0;
        exp_cnt = 8'h00;
        #1;
        chk("midrst_pready",  bus.pready,  0);
        chk("midrst_pslverr", bus.pslverr, 0);
        chk("midrst_prdata",  bus.prdata,  0);
        chk("midrst_ctrl",    ctrl_o,      8'h00);
        bus_idle();
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        chk("postrst_ctrl", ctrl_o, 8'h00);
        apb_xfer(1'b0, 8'h01, 8'h00, rd, er, nw, cd);
        chk("postrst_cnt", rd, 8'h00);
        chk("postrst_waits", nw, 0);
        bus_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
